// File: rtl/dmem_responder_if.sv
// ---------------------------------------------------------------------------
// dmem_responder_if
// Bundles the request/response handshake between the MEM pipeline stage and
// the data-memory responder.
//
// Signals:
//   req_valid    request present (master -> slave)
//   req_ready    responder can accept a request (slave -> master)
//   req_we       1 = store, 0 = load
//   req_size     00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned loads only: 1 = zero-extend, 0 = sign-extend
//   req_addr     byte address, little-endian
//   req_wdata    store data, right-aligned
//   rsp_valid    response present (slave -> master)
//   rsp_ready    consumer takes the response (master -> slave)
//   rsp_rdata    extended load result; 0 for stores and errors
//   rsp_err      request rejected, no memory access performed
//
// Modports: master (pipeline side), slave (responder side).
// ---------------------------------------------------------------------------
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the MEM pipeline stage. Accepts one load/store at
// a time, waits WAIT_STATES cycles, accesses an internal array of
// 2^ADDR_W 32-bit words with byte/half/word granularity and returns exactly
// one response per request (stores included). Misaligned or illegal-size
// requests are answered immediately with rsp_err=1 and never touch the array.
//
// Parameters:
//   ADDR_W       word-address width (array depth 2^ADDR_W words)
//   WAIT_STATES  cycles between accept and the access edge, 0..15
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous, active-high reset
//   bus  dmem_responder_if.slave (request/response handshake)
//
// Build option:
//   DMEM_BOUNDS_CHECK_EN  when defined, any nonzero address bit above the
//                         array range makes the request illegal; otherwise
//                         those bits are ignored and the address aliases.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int ADDR_W      = 13,
  parameter int WAIT_STATES = 1
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  logic              cap_we;
  logic [1:0]        cap_size;
  logic              cap_unsigned;
  logic [ADDR_W+1:0] cap_addr;
  logic [31:0]       cap_wdata;
  logic              capture;

  logic [31:0] rdata_q, rdata_next;
  logic        err_q, err_next;

  logic [31:0] mem [2**ADDR_W];

  logic              acc_we;
  logic [1:0]        acc_size;
  logic              acc_unsigned;
  logic [ADDR_W+1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-1:0] acc_idx;
  logic [1:0]        acc_lane;
  logic              do_access;
  logic              do_write;
  logic [3:0]        wmask;
  logic [31:0]       wlanes;
  logic [31:0]       rword;
  logic [31:0]       rshift;
  logic [31:0]       load_val;
  logic              out_of_range;
  logic              req_illegal;

  // Alignment rule: halves need an even address, words a 4-byte aligned one,
  // and size 11 is never legal.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return lane[0];
      2'b10:   return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

`ifdef DMEM_BOUNDS_CHECK_EN
  assign out_of_range = (bus.req_addr >> (ADDR_W + 2)) != 32'd0;
`else
  // Upper address bits are deliberately ignored so accesses alias.
  logic unused_upper_addr;
  assign out_of_range      = 1'b0;
  assign unused_upper_addr = ^bus.req_addr[31:ADDR_W+2];
`endif

  assign req_illegal = misaligned(bus.req_size, bus.req_addr[1:0]) | out_of_range;

  // With zero wait states the access happens on the accept edge itself, so
  // the access path reads the live request in IDLE and the captured copy
  // once the request has been parked in WAIT.
  always_comb begin
    if (state == IDLE) begin
      acc_we       = bus.req_we;
      acc_size     = bus.req_size;
      acc_unsigned = bus.req_unsigned;
      acc_addr     = bus.req_addr[ADDR_W+1:0];
      acc_wdata    = bus.req_wdata;
    end else begin
      acc_we       = cap_we;
      acc_size     = cap_size;
      acc_unsigned = cap_unsigned;
      acc_addr     = cap_addr;
      acc_wdata    = cap_wdata;
    end
  end

  assign acc_idx  = acc_addr[ADDR_W+1:2];
  assign acc_lane = acc_addr[1:0];

  // Load path: pick the word, shift the addressed lane down to bit 0, then
  // extend according to size and signedness.
  always_comb begin
    rword  = mem[acc_idx];
    rshift = rword >> {acc_lane, 3'b000};
    case (acc_size)
      2'b00:   load_val = acc_unsigned ? {24'd0, rshift[7:0]}
                                       : {{24{rshift[7]}}, rshift[7:0]};
      2'b01:   load_val = acc_unsigned ? {16'd0, rshift[15:0]}
                                       : {{16{rshift[15]}}, rshift[15:0]};
      default: load_val = rshift;
    endcase
  end

  // Store path: replicate the right-aligned data across all lanes and let the
  // byte mask pick which lanes actually get written.
  always_comb begin
    case (acc_size)
      2'b00: begin
        wmask  = 4'b0001 << acc_lane;
        wlanes = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        wmask  = 4'b0011 << acc_lane;
        wlanes = {2{acc_wdata[15:0]}};
      end
      default: begin
        wmask  = 4'b1111;
        wlanes = acc_wdata;
      end
    endcase
  end

  // Next-state logic. Errors skip the wait states entirely; legal requests
  // either access on the accept edge or count down in WAIT and access on the
  // edge where the counter reads 1.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rdata_next = rdata_q;
    err_next   = err_q;
    capture    = 1'b0;
    do_access  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          capture = 1'b1;
          if (req_illegal) begin
            state_next = RESP;
            err_next   = 1'b1;
            rdata_next = 32'd0;
          end else if (WAIT_STATES == 0) begin
            do_access  = 1'b1;
            state_next = RESP;
            err_next   = 1'b0;
            rdata_next = acc_we ? 32'd0 : load_val;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          cnt_next   = 4'd0;
          do_access  = 1'b1;
          state_next = RESP;
          err_next   = 1'b0;
          rdata_next = acc_we ? 32'd0 : load_val;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counter, captured request and response registers. Reset discards
  // any in-flight request, which also cancels a pending store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      rdata_q      <= 32'd0;
      err_q        <= 1'b0;
      cap_we       <= 1'b0;
      cap_size     <= 2'b00;
      cap_unsigned <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= 32'd0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      rdata_q <= rdata_next;
      err_q   <= err_next;
      if (capture) begin
        cap_we       <= bus.req_we;
        cap_size     <= bus.req_size;
        cap_unsigned <= bus.req_unsigned;
        cap_addr     <= bus.req_addr[ADDR_W+1:0];
        cap_wdata    <= bus.req_wdata;
      end
    end
  end

  // The array itself is not reset; rst only blocks the write strobe.
  assign do_write = do_access & acc_we & ~rst;

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask[i]) begin
          mem[acc_idx][i*8 +: 8] <= wlanes[i*8 +: 8];
        end
      end
    end
  end

  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder. Two instances share clk/rst: dut1 with
// one wait state carries most vectors, dut3 with three wait states covers the
// reset-during-WAIT case. `sel` steers the shared drive signals to one of
// them and muxes its outputs back for checking.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  bit          sel = 1'b0;

  logic        d_valid     = 1'b0;
  logic        d_we        = 1'b0;
  logic [1:0]  d_size      = 2'b00;
  logic        d_unsigned  = 1'b0;
  logic [31:0] d_addr      = 32'd0;
  logic [31:0] d_wdata     = 32'd0;
  logic        d_rsp_ready = 1'b0;

  logic        o_req_ready;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  int checks   = 0;
  int failures = 0;

  dmem_responder_if bus1();
  dmem_responder_if bus3();

  assign bus1.req_valid    = d_valid & ~sel;
  assign bus1.req_we       = d_we;
  assign bus1.req_size     = d_size;
  assign bus1.req_unsigned = d_unsigned;
  assign bus1.req_addr     = d_addr;
  assign bus1.req_wdata    = d_wdata;
  assign bus1.rsp_ready    = d_rsp_ready & ~sel;

  assign bus3.req_valid    = d_valid & sel;
  assign bus3.req_we       = d_we;
  assign bus3.req_size     = d_size;
  assign bus3.req_unsigned = d_unsigned;
  assign bus3.req_addr     = d_addr;
  assign bus3.req_wdata    = d_wdata;
  assign bus3.rsp_ready    = d_rsp_ready & sel;

  assign o_req_ready = sel ? bus3.req_ready : bus1.req_ready;
  assign o_rsp_valid = sel ? bus3.rsp_valid : bus1.rsp_valid;
  assign o_rsp_rdata = sel ? bus3.rsp_rdata : bus1.rsp_rdata;
  assign o_rsp_err   = sel ? bus3.rsp_err   : bus1.rsp_err;

  dmem_responder #(.ADDR_W(13), .WAIT_STATES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  dmem_responder #(.ADDR_W(13), .WAIT_STATES(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drives one request, waits for acceptance, measures cycles from the accept
  // edge to rsp_valid, captures the response and completes the handshake.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    d_valid     = 1'b1;
    d_we        = we;
    d_size      = size;
    d_unsigned  = uns;
    d_addr      = addr;
    d_wdata     = wdata;
    d_rsp_ready = 1'b0;
    n = 0;
    while (!o_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) checkOutput("accept_timeout", 32'(o_req_ready), 32'd1);
    @(negedge clk);
    d_valid = 1'b0;
    lat = 0;
    while (!o_rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = o_rsp_rdata;
    err   = o_rsp_err;
    d_rsp_ready = 1'b1;
    @(negedge clk);
    d_rsp_ready = 1'b0;
  endtask

  task automatic runCheck(input string tag, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    logic [31:0] r;
    logic        e;
    int          lat;
    applyStimulus(we, size, uns, addr, wdata, r, e, lat);
    checkOutput({tag, ".rdata"}, r, exp_rdata);
    checkOutput({tag, ".err"}, 32'(e), 32'(exp_err));
    checkOutput({tag, ".lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, ".req_ready"}, 32'(o_req_ready), 32'd0);
    checkOutput({tag, ".rsp_valid"}, 32'(o_rsp_valid), 32'd0);
    checkOutput({tag, ".rsp_rdata"}, o_rsp_rdata, 32'd0);
    checkOutput({tag, ".rsp_err"}, 32'(o_rsp_err), 32'd0);
  endtask

  initial begin
    int n;
    $display("[TB] start");

    // Reset state on both instances.
    repeat (3) @(negedge clk);
    sel = 1'b0;
    #1 checkResetOutputs("reset1");
    sel = 1'b1;
    #1 checkResetOutputs("reset3");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 checkOutput("reset1.ready_after", 32'(o_req_ready), 32'd1);

    // Word store then load, one wait state.
    runCheck("st_w10",  1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0,        1'b0, 1);
    runCheck("ld_w10",  1'b0, 2'b10, 1'b0, 32'h10, 32'd0,        32'hDEADBEEF, 1'b0, 1);

    // Byte stores with garbage in the upper data bits.
    runCheck("st_b20",  1'b1, 2'b00, 1'b0, 32'h20, 32'hFFFFFF11, 32'd0, 1'b0, 1);
    runCheck("st_b21",  1'b1, 2'b00, 1'b0, 32'h21, 32'hABCDEF22, 32'd0, 1'b0, 1);
    runCheck("st_b22",  1'b1, 2'b00, 1'b0, 32'h22, 32'h00000033, 32'd0, 1'b0, 1);
    runCheck("st_b23",  1'b1, 2'b00, 1'b0, 32'h23, 32'h12345680, 32'd0, 1'b0, 1);
    runCheck("ld_w20",  1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h80332211, 1'b0, 1);
    runCheck("lb_23",   1'b0, 2'b00, 1'b0, 32'h23, 32'd0, 32'hFFFFFF80, 1'b0, 1);
    runCheck("lbu_23",  1'b0, 2'b00, 1'b1, 32'h23, 32'd0, 32'h00000080, 1'b0, 1);
    runCheck("lb_21",   1'b0, 2'b00, 1'b0, 32'h21, 32'd0, 32'h00000022, 1'b0, 1);

    // Half-word loads.
    runCheck("st_w30",  1'b1, 2'b10, 1'b0, 32'h30, 32'h80017FFF, 32'd0, 1'b0, 1);
    runCheck("lh_32",   1'b0, 2'b01, 1'b0, 32'h32, 32'd0, 32'hFFFF8001, 1'b0, 1);
    runCheck("lhu_32",  1'b0, 2'b01, 1'b1, 32'h32, 32'd0, 32'h00008001, 1'b0, 1);
    runCheck("lh_30",   1'b0, 2'b01, 1'b0, 32'h30, 32'd0, 32'h00007FFF, 1'b0, 1);

    // Errors: answered right after the accept edge, nothing written.
    runCheck("err_w22", 1'b0, 2'b10, 1'b0, 32'h22, 32'd0,        32'd0, 1'b1, 0);
    runCheck("err_sz3", 1'b0, 2'b11, 1'b0, 32'h20, 32'd0,        32'd0, 1'b1, 0);
    runCheck("err_sh",  1'b1, 2'b01, 1'b0, 32'h21, 32'h0000FFFF, 32'd0, 1'b1, 0);
    runCheck("err_sw",  1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFFFFFF, 32'd0, 1'b1, 0);
    runCheck("ld_w20b", 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h80332211, 1'b0, 1);

    // Upper address bits: rejected with bounds checking, aliased otherwise.
    runCheck("st_w00",  1'b1, 2'b10, 1'b0, 32'h0, 32'hA5A50001, 32'd0, 1'b0, 1);
`ifdef DMEM_BOUNDS_CHECK_EN
    runCheck("ld_8000", 1'b0, 2'b10, 1'b0, 32'h8000, 32'd0, 32'd0, 1'b1, 0);
`else
    runCheck("ld_8000", 1'b0, 2'b10, 1'b0, 32'h8000, 32'd0, 32'hA5A50001, 1'b0, 1);
`endif

    // Backpressure: response held while a new request waits on req_valid.
    @(negedge clk);
    d_valid     = 1'b1;
    d_we        = 1'b0;
    d_size      = 2'b10;
    d_unsigned  = 1'b0;
    d_addr      = 32'h10;
    d_rsp_ready = 1'b0;
    checkOutput("bp.idle_ready", 32'(o_req_ready), 32'd1);
    @(negedge clk);
    d_addr = 32'h20;
    n = 0;
    while (!o_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp.first_rdata", o_rsp_rdata, 32'hDEADBEEF);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp.hold_valid", 32'(o_rsp_valid), 32'd1);
      checkOutput("bp.hold_rdata", o_rsp_rdata, 32'hDEADBEEF);
      checkOutput("bp.hold_err", 32'(o_rsp_err), 32'd0);
      checkOutput("bp.hold_ready", 32'(o_req_ready), 32'd0);
    end
    d_rsp_ready = 1'b1;
    @(negedge clk);
    d_rsp_ready = 1'b0;
    checkOutput("bp.rsp_cleared", 32'(o_rsp_valid), 32'd0);
    checkOutput("bp.ready_back", 32'(o_req_ready), 32'd1);
    @(negedge clk);
    d_valid = 1'b0;
    checkOutput("bp.second_busy", 32'(o_req_ready), 32'd0);
    @(negedge clk);
    checkOutput("bp.second_valid", 32'(o_rsp_valid), 32'd1);
    checkOutput("bp.second_rdata", o_rsp_rdata, 32'h80332211);
    d_rsp_ready = 1'b1;
    @(negedge clk);
    d_rsp_ready = 1'b0;

    // Three wait states, then reset while a store is parked in WAIT.
    sel = 1'b1;
    runCheck("ws3.st_40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678, 32'd0,        1'b0, 3);
    runCheck("ws3.ld_40", 1'b0, 2'b10, 1'b0, 32'h40, 32'd0,        32'h12345678, 1'b0, 3);
    @(negedge clk);
    d_valid = 1'b1;
    d_we    = 1'b1;
    d_size  = 2'b10;
    d_addr  = 32'h40;
    d_wdata = 32'hFFFFFFFF;
    checkOutput("ws3.idle_ready", 32'(o_req_ready), 32'd1);
    @(negedge clk);
    d_valid = 1'b0;
    checkOutput("ws3.in_wait", 32'(o_req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 checkResetOutputs("ws3.mid_reset");
    @(negedge clk);
    rst = 1'b0;
    runCheck("ws3.ld_after", 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 32'h12345678, 1'b0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
